// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared FSM state type and width default for the divider controller
package clk_div_pkg;

  localparam int DIV_RATIO_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2,
    WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/clk_div_ctrl_cnt.sv
// rtl/clk_div_ctrl_cnt.sv - loadable saturating down-counter shared by DRAIN and WAIT
module clk_div_ctrl_cnt
  import clk_div_pkg::*;
#(
  parameter int CNT_WIDTH = DIV_RATIO_WIDTH_DEF + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_load_val,
  input  logic                 i_dec,
  output logic                 o_zero
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Load wins over decrement; the count parks at zero instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - drains, reloads and re-enables a clock divider on ratio change
// CLK_DIV_CTRL_RATIO_CHECK_EN: reject ratios 0 and 1 with an o_err pulse instead of sequencing them
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_RATIO_WIDTH = DIV_RATIO_WIDTH_DEF,
  parameter int SETTLE_CYCLES   = 4,
  parameter int RESET_RATIO     = 1
) (
  input  logic                       i_ref_clk,
  input  logic                       i_rst_n,
  input  logic                       i_sys_en,
  input  logic                       i_req_valid,
  input  logic [DIV_RATIO_WIDTH-1:0] i_req_ratio,
  output logic                       o_req_ready,
  output logic [DIV_RATIO_WIDTH-1:0] o_div_ratio,
  output logic                       o_clk_en,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err
);

  localparam int                         CW          = DIV_RATIO_WIDTH + 1;
  localparam logic [CW-1:0]              SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [DIV_RATIO_WIDTH-1:0] RESET_VAL   = DIV_RATIO_WIDTH'(RESET_RATIO);

  state_e                     state_q;
  logic [DIV_RATIO_WIDTH-1:0] ratio_q;
  logic [DIV_RATIO_WIDTH-1:0] pend_q;
  logic                       clk_en_q;
  logic                       busy_q;
  logic                       done_q;

  logic          accept;
  logic          rejected;
  logic          same_ratio;
  logic          fast_done;
  logic          start_seq;
  logic          cnt_load;
  logic          cnt_dec;
  logic          cnt_zero;
  logic [CW-1:0] cnt_load_val;
  logic [CW-1:0] wait_load;

  assign o_req_ready = (state_q == IDLE);
  assign accept      = i_req_valid && o_req_ready;
  assign same_ratio  = (i_req_ratio == ratio_q);

`ifdef CLK_DIV_CTRL_RATIO_CHECK_EN
  logic err_q;
  assign rejected = accept && (i_req_ratio < DIV_RATIO_WIDTH'(2));
  assign o_err    = err_q;
`else
  assign rejected = 1'b0;
  assign o_err    = 1'b0;
`endif

  assign fast_done = accept && !rejected && same_ratio;
  assign start_seq = accept && !rejected && !same_ratio;

  // WAIT spans 2*R cycles (minimum 2); the counter is loaded with length-1.
  assign wait_load = (pend_q < DIV_RATIO_WIDTH'(2)) ? CW'(1)
                                                    : ({pend_q, 1'b0} - CW'(1));

  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = SETTLE_LOAD;
    cnt_dec      = 1'b0;
    unique case (state_q)
      IDLE:  cnt_load = start_seq;
      DRAIN: cnt_dec  = 1'b1;
      LOAD: begin
        cnt_load     = 1'b1;
        cnt_load_val = wait_load;
      end
      WAIT:  cnt_dec  = 1'b1;
      default: ;
    endcase
  end

  clk_div_ctrl_cnt #(
    .CNT_WIDTH (CW)
  ) u_cnt (
    .i_clk      (i_ref_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (cnt_load),
    .i_load_val (cnt_load_val),
    .i_dec      (cnt_dec),
    .o_zero     (cnt_zero)
  );

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      ratio_q  <= RESET_VAL;
      pend_q   <= '0;
      clk_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef CLK_DIV_CTRL_RATIO_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef CLK_DIV_CTRL_RATIO_CHECK_EN
      err_q  <= rejected;
`endif
      unique case (state_q)
        IDLE: begin
          clk_en_q <= i_sys_en;
          if (start_seq) begin
            pend_q   <= i_req_ratio;
            state_q  <= DRAIN;
            busy_q   <= 1'b1;
            clk_en_q <= 1'b0;
          end else if (fast_done) begin
            done_q   <= 1'b1;
          end
        end
        DRAIN: begin
          // The divider stays gated; i_sys_en is deliberately not sampled here.
          if (cnt_zero) begin
            state_q <= LOAD;
            ratio_q <= pend_q;
          end
        end
        LOAD: begin
          state_q  <= WAIT;
          clk_en_q <= i_sys_en;
        end
        WAIT: begin
          clk_en_q <= i_sys_en;
          if (cnt_zero) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_div_ratio = ratio_q;
  assign o_clk_en    = clk_en_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - directed vector bench for clk_div_ctrl (S=4, W=8)
module tb_clk_div_ctrl;

  logic       clk;
  logic       rst_n;
  logic       sys_en;
  logic       req_valid;
  logic [7:0] req_ratio;
  logic       req_ready;
  logic [7:0] div_ratio;
  logic       clk_en;
  logic       busy;
  logic       done;
  logic       err;

  int n_vec  = 0;
  int n_fail = 0;
  int viol   = 0;

  clk_div_ctrl #(
    .DIV_RATIO_WIDTH (8),
    .SETTLE_CYCLES   (4),
    .RESET_RATIO     (1)
  ) dut (
    .i_ref_clk   (clk),
    .i_rst_n     (rst_n),
    .i_sys_en    (sys_en),
    .i_req_valid (req_valid),
    .i_req_ratio (req_ratio),
    .o_req_ready (req_ready),
    .o_div_ratio (div_ratio),
    .o_clk_en    (clk_en),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        s;
    logic        v;
    logic [7:0]  r;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [12:0] outs();
    return {req_ready, div_ratio, clk_en, busy, done, err};
  endfunction

  task automatic add(input logic s, input logic v, input logic [7:0] r,
                     input logic rdy, input logic [7:0] div, input logic ce,
                     input logic bsy, input logic dn, input logic er);
    vec_t e;
    e.s   = s;
    e.v   = v;
    e.r   = r;
    e.exp = {rdy, div, ce, bsy, dn, er};
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = outs();
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b ratio=%0d en=%b busy=%b done=%b err=%b, expected rdy=%b ratio=%0d en=%b busy=%b done=%b err=%b",
               name, act[12], act[11:4], act[3], act[2], act[1], act[0],
               exp[12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Counts cycles (starting at index base) until o_done; 0 means the bound expired.
  task automatic wait_done(input int base, output int n, output logic early);
    n     = 0;
    early = 1'b0;
    for (int k = base; k < base + 100; k++) begin
      if (n == 0) begin
        @(negedge clk);
        if (done) begin
          n = k;
        end else begin
          if (req_ready) early = 1'b1;
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (done && err) viol++;
      if (done && prev_done) viol++;
    end
    prev_done = done;
  end

  int   n_cyc;
  logic early;
  int   pulses;
  int   bad_ratio;

  initial begin
    rst_n     = 1'b0;
    sys_en    = 1'b0;
    req_valid = 1'b0;
    req_ratio = 8'd0;

    add(1, 0, 0, 1, 1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 1, 0, 0, 0);
    add(1, 1, 6, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 1, 0, 1, 0, 0);
    add(1, 0, 0, 0, 6, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++)
      add((i == 4) ? 1'b0 : 1'b1, 0, 0, 0, 6, (i == 5) ? 1'b0 : 1'b1, 1, 0, 0);
    add(1, 0, 0, 1, 6, 1, 0, 1, 0);
    add(1, 1, 6, 1, 6, 1, 0, 0, 0);
    add(1, 0, 0, 1, 6, 1, 0, 1, 0);
    add(1, 0, 0, 1, 6, 1, 0, 0, 0);
    add(1, 1, 1, 1, 6, 1, 0, 0, 0);
`ifdef CLK_DIV_CTRL_RATIO_CHECK_EN
    add(1, 0, 0, 1, 6, 1, 0, 0, 1);
    add(1, 0, 0, 1, 6, 1, 0, 0, 0);
`else
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 6, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) add(1, 0, 0, 0, 1, 1, 1, 0, 0);
    add(1, 0, 0, 1, 1, 1, 0, 1, 0);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outs("reset_state", {1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      sys_en    = vecs[i].s;
      req_valid = vecs[i].v;
      req_ratio = vecs[i].r;
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), vecs[i].exp);
      @(posedge clk);
      #1;
    end

    // Second request held valid across a busy sequence
    sys_en    = 1'b1;
    req_valid = 1'b1;
    req_ratio = 8'd3;
    @(negedge clk);
    chk("hv_first_ready", 32'(req_ready), 1);
    @(posedge clk);
    #1;
    req_ratio = 8'd5;
    wait_done(1, n_cyc, early);
    chk("hv_done_cycle_r3", n_cyc, 12);
    chk("hv_ready_low_while_busy", 32'(early), 0);
    chk("hv_ready_at_done", 32'(req_ready), 1);
    chk("hv_ratio_at_done", 32'(div_ratio), 3);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk_outs("hv_accepted_in_done_cycle", {1'b0, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    wait_done(2, n_cyc, early);
    chk("hv_done_cycle_r5", n_cyc, 16);
    chk("hv_ratio_r5", 32'(div_ratio), 5);

    // Reset asserted at T+3 of a ratio-6 sequence
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_ratio = 8'd6;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("rst_busy_before", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("rst_async_values", {1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_outs("rst_first_cycle", {1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    pulses    = 0;
    bad_ratio = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || err) pulses++;
      if (div_ratio != 8'd1) bad_ratio++;
    end
    chk("rst_no_done_after", pulses, 0);
    chk("rst_ratio_held", bad_ratio, 0);
    chk("rst_clk_en_tracks", 32'(clk_en), 1);
    chk("done_err_exclusive_single", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
